jtpopeye_romarb: RTL and testbench

Parametrised SDRAM read arbiter that serves CHANNELS independent ROM clients (main CPU, object graphics, further graphics/sound ROMs in later boards) from one SDRAM read port. Each channel owns a one-word cache; misses are arbitrated round-robin and fetched with a toggle-request / fixed-latency protocol. It sits between the game top level and the SDRAM controller and replaces the fixed two-client ROM fetcher.

---
 rtl/jtpopeye_romarb.sv | 120 ++++++++++++
 tb/tb_jtpopeye_romarb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_romarb.sv
// Round-robin SDRAM read arbiter: one-word cache per ROM client, misses fetched
// through a toggle-request / fixed-latency SDRAM read port.
module jtpopeye_romarb #(
  parameter int                     CHANNELS = 2,
  parameter int                     AW       = 22,
  parameter int                     DW       = 32,
  parameter int                     LATENCY  = 4,
  parameter logic [CHANNELS*AW-1:0] OFFSETS  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   downloading,
  input  logic [CHANNELS-1:0]    ch_cs,
  input  logic [CHANNELS*AW-1:0] ch_addr,
  output logic [CHANNELS-1:0]    ch_ok,
  output logic [CHANNELS*DW-1:0] ch_dout,
  output logic                   sdram_re,
  output logic [AW-1:0]          sdram_addr,
  input  logic [DW-1:0]          data_read
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state, state_nxt;
  logic [CHANNELS-1:0] valid, hit, miss;
  logic [AW-1:0]       tag  [CHANNELS];
  logic [DW-1:0]       data [CHANNELS];
  logic [PW-1:0]       ptr, gnt, arb_gnt;
  logic                arb_found;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       req_addr, arb_addr, arb_abs;
  logic                grant, fill;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign hit[i]                = ch_cs[i] & valid[i] & (tag[i] == ch_addr[i*AW +: AW]);
    assign ch_dout[i*DW +: DW]   = data[i];
  end
  assign ch_ok = hit;

  // Search starts at ptr so the channel served last has lowest priority next.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    miss      = ch_cs & ~hit;
    arb_found = 1'b0;
    arb_gnt   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      logic [PW:0] idx;
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(CHANNELS)) idx = idx - (PW+1)'(CHANNELS);
      if (!arb_found && miss[idx[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_gnt   = idx[PW-1:0];
      end
    end
  end

  assign arb_addr = ch_addr[arb_gnt*AW +: AW];
  assign arb_abs  = arb_addr + OFFSETS[arb_gnt*AW +: AW];

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: if (!downloading && arb_found) begin
        grant     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (downloading) begin
        state_nxt = IDLE;
      end else if (cnt == '0) begin
        fill      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      ptr        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      sdram_re   <= 1'b0;
      sdram_addr <= '0;
      req_addr   <= '0;
      // NOTE: the cache arrays are only a few words, so they are cleared to give a defined ch_dout after reset.
      for (int i = 0; i < CHANNELS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt        <= arb_gnt;
        req_addr   <= arb_addr;
        sdram_addr <= arb_abs;
        sdram_re   <= ~sdram_re;
        cnt        <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      // The tag is the address latched at grant; a client that moved on misses again.
      if (fill) begin
        data[gnt]  <= data_read;
        tag[gnt]   <= req_addr;
        valid[gnt] <= 1'b1;
        ptr        <= (gnt == PW'(CHANNELS - 1)) ? '0 : gnt + PW'(1);
      end
      if (downloading) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jtpopeye_romarb.sv
// Scoreboard bench for jtpopeye_romarb: clients push expected words, a monitor
// pops them when ch_ok rises; an SDRAM model answers each sdram_re edge.
module tb_jtpopeye_romarb;

  localparam int CH  = 2;
  localparam int AW  = 22;
  localparam int DW  = 32;
  localparam int LAT = 4;
  localparam logic [AW-1:0] OFF0 = 22'h000100;
  localparam logic [AW-1:0] OFF1 = 22'h3FFFF0;

  logic              clk, rst_n, downloading;
  logic [CH-1:0]     ch_cs, ch_ok;
  logic [CH*AW-1:0]  ch_addr;
  logic [CH*DW-1:0]  ch_dout;
  logic              sdram_re;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     data_read;

  jtpopeye_romarb #(
    .CHANNELS(CH), .AW(AW), .DW(DW), .LATENCY(LAT), .OFFSETS({OFF1, OFF0})
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_ok(ch_ok), .ch_dout(ch_dout),
    .sdram_re(sdram_re), .sdram_addr(sdram_addr), .data_read(data_read)
  );

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            grant_q[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, edges = 0, edge_cyc = 0;
  logic [AW-1:0] last_req = '0;
  logic [AW-1:0] model_tag [CH];
  bit            model_valid [CH];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[9:0], a} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [AW-1:0] abs_addr(input int ch, input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = (ch == 0) ? a + OFF0 : a + OFF1;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any ch_ok must show the memory word of the current address; each
  // rising ch_ok consumes the oldest expectation pushed for that channel.
  initial begin
    logic [CH-1:0] prev_ok;
    int            idx;
    prev_ok = '0;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < CH; i++) begin
        if (ch_ok[i])
          check("dout_vs_mem", ch_dout[i*DW +: DW], mem_word(abs_addr(i, ch_addr[i*AW +: AW])));
        if (ch_ok[i] && !prev_ok[i]) begin
          idx = -1;
          foreach (exp_q[j]) if (idx < 0 && exp_q[j].ch == i) idx = j;
          if (idx < 0) check("ok_without_request", ch_ok[i], 1'b0);
          else begin
            check("ok_addr", ch_addr[i*AW +: AW], exp_q[idx].addr);
            check("ok_data", ch_dout[i*DW +: DW], exp_q[idx].data);
            exp_q.delete(idx);
          end
        end
      end
      prev_ok = ch_ok;
    end
  end

  // SDRAM model: each sdram_re edge returns mem_word(addr) only for the cycle
  // that the fixed latency says will be sampled; random data otherwise.
  initial begin
    logic          prev_re, prev_dl;
    logic [AW-1:0] pend_addr, last_addr;
    int            pend, gch;
    prev_re = 1'b0; prev_dl = 1'b0; pend = 0; pend_addr = '0; last_addr = '0;
    data_read = '0;
    forever begin
      @(negedge clk); #1;
      if (pend > 0) begin
        pend--;
        data_read = (pend == 0) ? mem_word(pend_addr) : $urandom;
      end else begin
        data_read = $urandom;
      end
      if (rst_n && sdram_re !== prev_re) begin
        if (prev_dl) check("edge_while_downloading", sdram_re, prev_re);
        check("one_request_in_flight", pend, 0);
        gch = -1;
        for (int c = 0; c < CH; c++)
          if (gch < 0 && ch_cs[c] && abs_addr(c, ch_addr[c*AW +: AW]) == sdram_addr) gch = c;
        check("sdram_addr_matches_client", gch >= 0, 1'b1);
        grant_q.push_back(gch);
        last_req  = sdram_addr;
        edge_cyc  = cyc;
        edges++;
        pend      = LAT - 1;
        pend_addr = sdram_addr;
        prev_re   = sdram_re;
        last_addr = sdram_addr;
      end else if (rst_n) begin
        check("sdram_addr_stable", sdram_addr, last_addr);
      end
      prev_dl = downloading;
    end
  end

  task automatic client_req(input int ch, input logic [AW-1:0] a, input bit exp_hit, output int lat);
    exp_t e;
    @(negedge clk);
    if (ch_cs[ch] && ch_addr[ch*AW +: AW] == a) begin
      ch_cs[ch] = 1'b0;
      @(negedge clk);
    end
    e.ch = ch; e.addr = a; e.data = mem_word(abs_addr(ch, a));
    exp_q.push_back(e);
    ch_addr[ch*AW +: AW] = a;
    ch_cs[ch] = 1'b1;
    lat = 0;
    #1;
    while (!ch_ok[ch] && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    check("ok_timeout", ch_ok[ch], 1'b1);
    if (exp_hit) check("hit_latency", lat, 0);
    else check("miss_latency_in_range", (lat >= LAT + 1) && (lat <= CH * (LAT + 1)), 1'b1);
    model_tag[ch]   = a;
    model_valid[ch] = 1'b1;
  endtask

  task automatic wait_edges(input int target);
    int n = 0;
    while (edges < target && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    check("edge_timeout", edges >= target, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk); #2;
      n++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  task automatic push_exp(input int ch, input logic [AW-1:0] a);
    exp_t e;
    e.ch = ch; e.addr = a; e.data = mem_word(abs_addr(ch, a));
    exp_q.push_back(e);
  endtask

  task automatic rr_client(input int ch);
    int lat;
    for (int k = 0; k < 6; k++)
      client_req(ch, (ch == 0 ? 22'h80 : 22'h40) + AW'(k), 1'b0, lat);
  endtask

  task automatic rand_client(input int ch, input int n);
    int            lat;
    logic [AW-1:0] a;
    bit            h;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        ch_cs[ch] = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      a = (ch == 0 ? 22'h0 : 22'h20) + AW'($urandom_range(0, 3));
      h = model_valid[ch] && model_tag[ch] == a;
      client_req(ch, a, h, lat);
    end
    @(negedge clk);
    ch_cs[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_e, t0;
    rst_n = 1'b0; downloading = 1'b0;
    ch_cs = 2'b11;
    ch_addr = {22'h000021, 22'h000005};
    for (int i = 0; i < CH; i++) begin model_valid[i] = 1'b0; model_tag[i] = '0; end

    // Reset with both clients requesting.
    repeat (3) @(negedge clk);
    #1;
    check("reset_ok", ch_ok, 2'b00);
    check("reset_re", sdram_re, 1'b0);
    check("reset_addr", sdram_addr, 22'h0);
    check("reset_dout", ch_dout, 64'h0);
    @(negedge clk);
    push_exp(0, 22'h5);
    push_exp(1, 22'h21);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("first_edge_after_reset", sdram_re, 1'b1);
    check("first_grant_ch0_addr", sdram_addr, 22'h000105);
    drain();
    model_tag[0] = 22'h5;  model_valid[0] = 1'b1;
    model_tag[1] = 22'h21; model_valid[1] = 1'b1;
    @(negedge clk);
    ch_cs = 2'b00;

    // Single miss on ch1, then a hit on the same address.
    n_e = edges;
    client_req(1, 22'h23, 1'b0, lat);
    check("single_miss_latency", lat, LAT + 1);
    check("single_miss_sdram_addr", last_req, 22'h000013);
    check("single_miss_one_edge", edges, n_e + 1);
    client_req(1, 22'h23, 1'b1, lat);
    check("hit_no_new_edge", edges, n_e + 1);

    // Offset addition wraps modulo 2^AW.
    client_req(1, 22'h20, 1'b0, lat);
    check("offset_wrap", last_req, 22'h000010);

    // Address change while the fetch is in flight.
    @(negedge clk);
    ch_cs = 2'b00;
    n_e = edges;
    @(negedge clk);
    ch_addr[0 +: AW] = 22'h10;
    ch_cs[0] = 1'b1;
    wait_edges(n_e + 1);
    t0 = edge_cyc;
    @(negedge clk);
    ch_addr[0 +: AW] = 22'h11;
    push_exp(0, 22'h11);
    for (int n = 0; n < 40 && edges < n_e + 2; n++) begin
      @(negedge clk); #2;
      check("ok_low_on_stale_tag", ch_ok[0], 1'b0);
    end
    check("refetch_addr", last_req, 22'h000111);
    check("refetch_after_idle", edge_cyc - t0, LAT + 1);
    drain();
    model_tag[0] = 22'h11;

    // downloading asserted mid-fetch aborts it and invalidates the caches.
    @(negedge clk);
    ch_cs = 2'b00;
    n_e = edges;
    @(negedge clk);
    push_exp(1, 22'h50);
    ch_addr[AW +: AW] = 22'h50;
    ch_cs[1] = 1'b1;
    wait_edges(n_e + 1);
    t0 = edge_cyc;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
    push_exp(0, 22'h11);
    ch_cs[0] = 1'b1;
    #2;
    check("ok_during_download", ch_ok, 2'b00);
    @(negedge clk);
    downloading = 1'b0;
    #2;
    check("ok_after_download", ch_ok, 2'b00);
    wait_edges(n_e + 2);
    check("refetch_after_download", edge_cyc - t0, LAT);
    drain();
    model_tag[1] = 22'h50;

    // Round-robin with both channels missing continuously.
    @(negedge clk);
    ch_cs = 2'b00;
    grant_q.delete();
    fork
      rr_client(0);
      rr_client(1);
    join
    check("rr_grant_count", grant_q.size(), 12);
    for (int k = 1; k < grant_q.size(); k++)
      check("rr_alternate", grant_q[k] != grant_q[k-1], 1'b1);
    drain();
    @(negedge clk);
    ch_cs = 2'b00;

    // Randomized concurrent traffic with frequent re-hits.
    fork
      rand_client(0, 25);
      rand_client(1, 25);
    join
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
